// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD control path.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SUB_A = 3'd3,
    SUB_B = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic RES_A = 1'b0;
  localparam logic RES_B = 1'b1;

  localparam int unsigned DW = 16;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Saturating subtraction-step counter with synchronous clear and a limit flag.
module gcd_iter_cnt #(
  parameter int unsigned MAX_ITER = 65535,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == Limit);

  // Holding at the limit keeps the count from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_ctrl.sv
// GCD controller: sequences the A/B datapath registers through subtraction-based GCD
// behind valid/ready handshakes, with a bounded step count.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned MAX_ITER = 65535,
  parameter int unsigned CNT_W    = DW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic a_is_zero,
  input  logic b_is_zero,
  input  logic lt,
  input  logic gt,
  input  logic eq,
  output logic ld_a,
  output logic ld_b,
  output logic sel_in,
  output logic sub_sel,
  output logic res_sel,
  output logic err,
  output logic out_valid,
  input  logic out_ready,
  output logic busy
);

  state_e state_q, state_d;
  logic   res_sel_q, res_sel_d;
  logic   err_q, err_d;
  logic   at_limit;

  gcd_iter_cnt #(
    .MAX_ITER(MAX_ITER),
    .CNT_W   (CNT_W)
  ) u_iter_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == LOAD),
    .en      ((state_q == SUB_A) || (state_q == SUB_B)),
    .at_limit(at_limit)
  );

  always_comb begin
    state_d   = state_q;
    res_sel_d = res_sel_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = LOAD;
      end
      LOAD: state_d = CHECK;
      CHECK: begin
        state_d   = DONE;
        res_sel_d = RES_A;
        if (a_is_zero && b_is_zero) begin
          err_d = 1'b1;
        end else if (a_is_zero) begin
          res_sel_d = RES_B;
        end else if (b_is_zero) begin
          res_sel_d = RES_A;
        end else if (!$onehot({lt, gt, eq})) begin
          // Inconsistent comparator flags: refuse to produce a result.
          err_d = 1'b1;
        end else if (eq) begin
          res_sel_d = RES_A;
        end else if (at_limit) begin
          err_d = 1'b1;
        end else if (gt) begin
          state_d = SUB_A;
        end else begin
          state_d = SUB_B;
        end
      end
      SUB_A: state_d = CHECK;
      SUB_B: state_d = CHECK;
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      res_sel_q <= RES_A;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_sel_q <= res_sel_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ld_a      = (state_q == LOAD) || (state_q == SUB_A);
  assign ld_b      = (state_q == LOAD) || (state_q == SUB_B);
  assign sel_in    = (state_q == LOAD);
  assign sub_sel   = (state_q == SUB_B);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_sel   = res_sel_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: behavioural A/B datapath plus a scoreboard of expected results.
module tb_gcd_ctrl;

  localparam int unsigned MaxIter  = 16;
  localparam int          LatBound = 200;

  typedef struct {
    logic [15:0] val;
    logic        rsel;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, ld_a, ld_b, sel_in, sub_sel, res_sel, err, out_valid, busy;
  logic a_is_zero, b_is_zero, lt, gt, eq;

  logic [15:0] din_a = '0, din_b = '0;
  logic [15:0] a_r = '0, b_r = '0;
  logic [15:0] diff;
  logic        force_ill = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  gcd_ctrl #(
    .MAX_ITER(MaxIter),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_is_zero(a_is_zero),
    .b_is_zero(b_is_zero),
    .lt       (lt),
    .gt       (gt),
    .eq       (eq),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .sel_in   (sel_in),
    .sub_sel  (sub_sel),
    .res_sel  (res_sel),
    .err      (err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // Behavioural datapath
  assign diff      = sub_sel ? (b_r - a_r) : (a_r - b_r);
  assign a_is_zero = (a_r == 16'd0);
  assign b_is_zero = (b_r == 16'd0);
  assign lt        = force_ill ? 1'b1 : (a_r < b_r);
  assign gt        = force_ill ? 1'b1 : (a_r > b_r);
  assign eq        = force_ill ? 1'b0 : (a_r == b_r);

  always @(posedge clk) begin
    if (ld_a) a_r <= sel_in ? din_a : diff;
    if (ld_b) b_r <= sel_in ? din_b : diff;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a_in, input logic [15:0] b_in, input bit ill);
    exp_t        e;
    logic [15:0] a, b;
    int          steps;
    a = a_in; b = b_in; steps = 0;
    e.val = '0; e.rsel = 1'b0; e.err = 1'b0;
    if (a == 0 && b == 0) begin
      e.err = 1'b1;
    end else if (a == 0) begin
      e.rsel = 1'b1;
      e.val  = b;
    end else if (b == 0) begin
      e.val = a;
    end else if (ill) begin
      e.err = 1'b1;
    end else begin
      while (a != b) begin
        if (steps == int'(MaxIter)) begin
          e.err = 1'b1;
          break;
        end
        if (a > b) a = a - b;
        else       b = b - a;
        steps++;
      end
      if (!e.err) e.val = a;
    end
    e.lat = 2 + 2 * steps;
    return e;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit ill, input int hold);
    exp_t e;
    int   cyc;
    sb_q.push_back(model(a, b, ill));
    force_ill = ill;
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    din_a    = a;
    din_b    = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < LatBound) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    check_eq("out_valid", out_valid, 1);
    check_eq("latency", cyc, e.lat);
    check_eq("busy_done", busy, 1);
    check_eq("res_sel", res_sel, e.rsel);
    check_eq("err", err, e.err);
    if (!e.err) check_eq("result", res_sel ? b_r : a_r, e.val);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_res_sel", res_sel, e.rsel);
      check_eq("hold_err", err, e.err);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    force_ill = 1'b0;
    check_eq("valid_dropped", out_valid, 0);
    check_eq("in_ready_back", in_ready, 1);
    check_eq("err_cleared", err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ld", {ld_a, ld_b, sel_in, sub_sel}, 0);
    check_eq("rst_res_sel", res_sel, 0);
    check_eq("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd12, 16'd8, 1'b0, 0);
    run_op(16'd0, 16'd9, 1'b0, 0);
    run_op(16'd0, 16'd0, 1'b0, 0);
    run_op(16'd65535, 16'd1, 1'b0, 0);
    run_op(16'd12, 16'd8, 1'b0, 10);

    // Reset during SUB_B of (100,75): LOAD, CHECK, SUB_A, CHECK, SUB_B
    @(negedge clk);
    din_a    = 16'd100;
    din_b    = 16'd75;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_eq("in_sub_b", {ld_b, sub_sel}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd21, 16'd14, 1'b0, 0);
    run_op(16'd5, 16'd3, 1'b1, 0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
Control path for the GCD unit. Sequences the datapath's operand registers A and B (16-bit parallel-load registers with a load enable) through the subtraction-based GCD algorithm. Takes comparator and zero flags from the datapath and drives load enables and mux selects. Wraps the computation in a valid/ready handshake on the input and output sides, and bounds runtime with an iteration counter.

Parameters:
MAX_ITER, 65535, subtraction-step limit; reaching it aborts with err=1
CNT_W, 16, iteration counter width; must satisfy 2**CNT_W > MAX_ITER

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operands valid on datapath input bus
in_ready  output  1  controller can accept operands
a_is_zero  input  1  datapath: A register == 0
b_is_zero  input  1  datapath: B register == 0
lt  input  1  datapath: A < B (unsigned)
gt  input  1  datapath: A > B (unsigned)
eq  input  1  datapath: A == B
ld_a  output  1  load enable, A register
ld_b  output  1  load enable, B register
sel_in  output  1  1 = registers take external operands; 0 = subtractor output
sub_sel  output  1  0 = subtractor computes A-B; 1 = B-A
res_sel  output  1  result location: 0 = A, 1 = B; valid while out_valid
err  output  1  result invalid (both operands zero, or MAX_ITER hit); valid while out_valid
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, iteration count=0, res_sel=0, err=0.
- Output values under reset: ld_a=ld_b=sel_in=sub_sel=out_valid=busy=0 and in_ready=1. Upstream must hold in_valid=0 while rst_n=0.
- Reset asserted mid-operation aborts immediately with no result. A and B are left unspecified.
- All outputs are Moore decodes of state or registered flags. No combinational path from any input to any output.
- IDLE: in_ready=1. Transfer occurs on in_valid&in_ready → LOAD.
- LOAD: ld_a=ld_b=1, sel_in=1. Clear iteration count → CHECK.
- CHECK: flags reflect register contents from the previous edge. Priority order:
  - a_is_zero&b_is_zero → DONE, err=1, res_sel=0
  - a_is_zero → DONE, res_sel=1
  - b_is_zero → DONE, res_sel=0
  - eq → DONE, res_sel=0
  - count==MAX_ITER → DONE, err=1, res_sel=0
  - gt → SUB_A
  - lt → SUB_B
- SUB_A: ld_a=1, sel_in=0, sub_sel=0 (A<=A-B). Count+1 → CHECK.
- SUB_B: ld_b=1, sel_in=0, sub_sel=1 (B<=B-A). Count+1 → CHECK.
- DONE: out_valid=1. res_sel and err hold stable until transfer. On out_ready → IDLE; err is cleared on leaving DONE.
- Backpressure: out_ready low holds DONE indefinitely. in_ready=0 throughout.
- The count saturates and never wraps; the CHECK limit test fires first.
- Latency: k subtraction steps give out_valid high exactly 2+2k cycles after the input transfer edge. Throughput: one result per 4+2k cycles with out_ready tied high.
- Illegal flag combination in CHECK (none or more than one of lt/gt/eq) → DONE with err=1.
- Unreachable state encodings → IDLE.

Decomposition:
- Shared package gcd_pkg holds:
  - state encoding constants: IDLE, LOAD, CHECK, SUB_A, SUB_B, DONE (3-bit)
  - RES_A=0, RES_B=1
  - datapath width constant DW=16
- One natural sub-module: gcd_iter_cnt, a saturating counter with clear, enable and an at_limit flag.
- Next-state and output decode stay in gcd_ctrl.

Test Plan:
1. Operands (12,8) with a behavioural datapath → SUB_A, SUB_B, then eq. out_valid 6 cycles after transfer, res_sel=0 (A=4), err=0.
2. Operands (0,9) → DONE after LOAD and CHECK: out_valid 2 cycles after transfer, res_sel=1, err=0. Operands (0,0) → err=1.
3. Operands (65535,1) with MAX_ITER=16 → err=1 after exactly 16 SUB_A steps; out_valid 34 cycles after transfer.
4. Result ready with out_ready held low 10 cycles → out_valid, res_sel and err stable; in_ready=0 throughout. out_ready=1 → IDLE the next cycle, in_ready=1.
5. rst_n pulsed low during SUB_B of operands (100,75) → immediately out_valid=0, busy=0, in_ready=1. Subsequent operands (21,14) → res_sel=0, A=7, err=0.
6. Force lt=gt=1 in CHECK → DONE with err=1.
